// File: rtl/count_seq_checker.sv
// Sequence monitor for a free-running binary up-counter: locks onto the observed
// count, flags wraps, and pulses/counts increment errors once locked.
module count_seq_checker #(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned ERR_W    = 8,
    parameter int unsigned SYNC_LEN = 2
) (
    input  logic             clk,
    input  logic             res,
    input  logic [WIDTH-1:0] count_in,
    input  logic             cnt_valid,
    input  logic             obs_res,
    output logic             locked,
    output logic [WIDTH-1:0] expected,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_count
);

    // Wide enough to hold SYNC_LEN itself.
    localparam int unsigned RUN_W = (SYNC_LEN < 2) ? 1 : $clog2(SYNC_LEN + 1);

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StLock
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic               wrap_pulse_q, wrap_pulse_d;

    logic [WIDTH-1:0]   prev_inc;
    logic [RUN_W-1:0]   run_inc;
    logic               match;

    assign prev_inc = prev_q + 1'b1;
    assign run_inc  = run_q + 1'b1;
    assign match    = (count_in == prev_inc);

    // Next-state logic: obs_res wins over any sample; pulses default low.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        run_d        = run_q;
        err_d        = err_q;
        locked_d     = locked_q;
        err_pulse_d  = 1'b0;
        wrap_pulse_d = 1'b0;

        if (obs_res) begin
            state_d  = StIdle;
            locked_d = 1'b0;
            run_d    = '0;
        end else if (cnt_valid) begin
            unique case (state_q)
                StIdle: begin
                    prev_d  = count_in;
                    run_d   = '0;
                    state_d = StSync;
                end
                StSync: begin
                    prev_d = count_in;
                    if (match) begin
                        run_d = run_inc;
                        if (run_inc == RUN_W'(SYNC_LEN)) begin
                            state_d  = StLock;
                            locked_d = 1'b1;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                StLock: begin
                    prev_d = count_in;
                    if (match) begin
                        wrap_pulse_d = (prev_q == '1);
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_q != '1) begin
                            err_d = err_q + 1'b1;
                        end
                        locked_d = 1'b0;
                        run_d    = '0;
                        state_d  = StSync;
                    end
                end
                default: begin
                    state_d  = StIdle;
                    locked_d = 1'b0;
                    run_d    = '0;
                end
            endcase
        end
    end

    // State register with synchronous reset overriding all inputs.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q      <= StIdle;
            prev_q       <= '0;
            run_q        <= '0;
            err_q        <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            run_q        <= run_d;
            err_q        <= err_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            wrap_pulse_q <= wrap_pulse_d;
        end
    end

    // Outputs come straight from registers; expected is forced to 0 while idle.
    always_comb begin
        locked     = locked_q;
        err_pulse  = err_pulse_q;
        wrap_pulse = wrap_pulse_q;
        err_count  = err_q;
        expected   = (state_q == StIdle) ? '0 : prev_inc;
    end

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: directed scenarios then random traffic, checked
// against a behavioural model. A second instance with a 2-bit error counter
// shares the inputs to exercise saturation.
module tb_count_seq_checker;

    localparam int SYNC_LEN = 2;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic [2:0] count_in = '0;
    logic       cnt_valid = 1'b0;
    logic       obs_res = 1'b0;

    logic       locked, err_pulse, wrap_pulse;
    logic [2:0] expected;
    logic [7:0] err_count;
    logic       locked2, err_pulse2, wrap_pulse2;
    logic [2:0] expected2;
    logic [1:0] err_count2;

    int total = 0;
    int bad = 0;

    // Model: mode 0 idle, 1 syncing, 2 locked.
    int m_mode = 0;
    int m_prev = 0;
    int m_run = 0;
    int m_err8 = 0;
    int m_err2 = 0;
    int m_errp = 0;
    int m_wrap = 0;

    always #5 clk = ~clk;

    count_seq_checker #(.WIDTH(3), .ERR_W(8), .SYNC_LEN(SYNC_LEN)) dut (
        .clk(clk), .res(res), .count_in(count_in), .cnt_valid(cnt_valid),
        .obs_res(obs_res), .locked(locked), .expected(expected),
        .err_pulse(err_pulse), .wrap_pulse(wrap_pulse), .err_count(err_count)
    );

    count_seq_checker #(.WIDTH(3), .ERR_W(2), .SYNC_LEN(SYNC_LEN)) dut2 (
        .clk(clk), .res(res), .count_in(count_in), .cnt_valid(cnt_valid),
        .obs_res(obs_res), .locked(locked2), .expected(expected2),
        .err_pulse(err_pulse2), .wrap_pulse(wrap_pulse2), .err_count(err_count2)
    );

    task automatic chk(input string tag, input int obs, input int exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_step(input int r, input int o, input int v, input int c);
        m_errp = 0;
        m_wrap = 0;
        if (r != 0) begin
            m_mode = 0; m_prev = 0; m_run = 0; m_err8 = 0; m_err2 = 0;
        end else if (o != 0) begin
            m_mode = 0; m_run = 0;
        end else if (v != 0) begin
            if (m_mode == 0) begin
                m_mode = 1; m_run = 0;
            end else if (c == (m_prev + 1) % 8) begin
                if (m_mode == 2) begin
                    m_wrap = (c == 0) ? 1 : 0;
                end else begin
                    m_run++;
                    if (m_run == SYNC_LEN) m_mode = 2;
                end
            end else begin
                if (m_mode == 2) begin
                    m_errp = 1;
                    m_err8 = (m_err8 < 255) ? m_err8 + 1 : 255;
                    m_err2 = (m_err2 < 3) ? m_err2 + 1 : 3;
                    m_mode = 1;
                end
                m_run = 0;
            end
            m_prev = c;
        end
    endtask

    // Drive one cycle, advance the model, then compare every output.
    task automatic step(input int r, input int o, input int v, input int c);
        res = r[0]; obs_res = o[0]; cnt_valid = v[0]; count_in = c[2:0];
        model_step(r, o, v, c);
        @(posedge clk);
        #1;
        chk("locked", int'(locked), (m_mode == 2) ? 1 : 0);
        chk("expected", int'(expected), (m_mode == 0) ? 0 : (m_prev + 1) % 8);
        chk("err_pulse", int'(err_pulse), m_errp);
        chk("wrap_pulse", int'(wrap_pulse), m_wrap);
        chk("err_count", int'(err_count), m_err8);
        chk("err_count_w2", int'(err_count2), m_err2);
        chk("locked_w2", int'(locked2), (m_mode == 2) ? 1 : 0);
    endtask

    task automatic sample(input int c);
        step(0, 0, 1, c);
    endtask

    int drv;

    initial begin
        // 1: reset then 0,1,2,3
        step(1, 0, 0, 0);
        chk("reset_expected", int'(expected), 0);
        sample(0); sample(1); sample(2);
        chk("lock_after_2", int'(locked), 1);
        chk("expected_3", int'(expected), 3);
        sample(3);

        // 2: wrap through 7 -> 0
        sample(4); sample(5); sample(6); sample(7); sample(0);
        chk("wrap_seen", int'(wrap_pulse), 1);
        sample(1);
        chk("wrap_one_cycle", int'(wrap_pulse), 0);

        // 3: expected 4, feed 5 -> error, then relock on 6,7
        sample(2); sample(3); sample(5);
        chk("err_seen", int'(err_pulse), 1);
        chk("err_count_1", int'(err_count), 1);
        sample(6); sample(7);
        chk("relock", int'(locked), 1);

        // 4: obs_res while locked, restart from 0
        sample(0); sample(1); sample(2); sample(3); sample(4); sample(5);
        step(0, 1, 1, 3);
        chk("obs_res_unlock", int'(locked), 0);
        sample(0); sample(1); sample(2);
        chk("obs_res_relock", int'(locked), 1);
        chk("obs_res_no_err", int'(err_count), 1);

        // 5: gaps in cnt_valid
        step(1, 0, 0, 0);
        sample(2); step(0, 0, 0, 6); step(0, 0, 0, 1); sample(3); sample(4);
        chk("gap_lock", int'(locked), 1);

        // 6: five mismatches with relock between; narrow counter saturates
        for (int i = 0; i < 5; i++) begin
            drv = (int'(expected) + 3) % 8;
            sample(drv); sample((drv + 1) % 8); sample((drv + 2) % 8);
        end
        chk("sat_w2", int'(err_count2), 3);
        chk("err_w8_5", int'(err_count), 5);
        step(1, 0, 1, 4);
        chk("mid_res_err", int'(err_count2), 0);

        // Random traffic: mostly clean increments with occasional jumps/resets.
        drv = $urandom_range(0, 7);
        for (int i = 0; i < 3000; i++) begin
            int r, o, v;
            r = ($urandom_range(0, 199) == 0) ? 1 : 0;
            o = ($urandom_range(0, 59) == 0) ? 1 : 0;
            v = ($urandom_range(0, 9) < 8) ? 1 : 0;
            if (v != 0) begin
                if ($urandom_range(0, 15) == 0) drv = $urandom_range(0, 7);
                else drv = (drv + 1) % 8;
            end
            step(r, o, v, drv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
